// File: rtl/zmips_pkg.sv
// Shared constants and types for the zmips register file slice.
package zmips_pkg;

    localparam int ZMIPS_DW   = 32;
    localparam int ZMIPS_NREG = 32;
    localparam int ZMIPS_AW   = 5;

    typedef logic [ZMIPS_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/zmips_sb_vec.sv
// Per-register pending scoreboard: load issue sets a bit, load writeback clears it.
module zmips_sb_vec
    import zmips_pkg::*;
#(
    parameter int NREG    = ZMIPS_NREG,
    parameter int AW      = ZMIPS_AW,
    parameter int ZERO_R0 = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] pend,
    output logic            any_busy
);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;

    // Set is applied after clear so a back-to-back load to the same register stays pending.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < NREG; i++) begin
            if (set_en && set_addr == AW'(i)) begin
                w_pend_nxt[i] = 1'b1;
            end else if (clr_en && clr_addr == AW'(i)) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
        if (ZERO_R0 != 0) begin
            w_pend_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign pend     = r_pend;
    assign any_busy = |r_pend;

endmodule

// File: rtl/zmips_regfile_sb.sv
// Multi-read-port register file with prioritised ALU/load write ports,
// write-to-read bypass and a load-use pending scoreboard.
module zmips_regfile_sb
    import zmips_pkg::*;
#(
    parameter int DW      = ZMIPS_DW,
    parameter int NREG    = ZMIPS_NREG,
    parameter int AW      = ZMIPS_AW,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]  rd_busy,
    input  logic               wa_en,
    input  logic [AW-1:0]      wa_addr,
    input  logic [DW-1:0]      wa_data,
    input  logic               wb_en,
    input  logic [AW-1:0]      wb_addr,
    input  logic [DW-1:0]      wb_data,
    input  logic               wb_clr,
    input  logic               sb_set,
    input  logic [AW-1:0]      sb_addr,
    output logic               any_busy
);

    if (NREG != (1 << AW)) begin : g_chk_nreg
        $error("zmips_regfile_sb: NREG must equal 2**AW");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_chk_nrd
        $error("zmips_regfile_sb: NUM_RD must be 1..4");
    end

    localparam logic [AW-1:0] W_ZERO_ADDR = AW'(REG_ZERO);

    logic [DW-1:0]   r_mem [NREG];
    logic [NREG-1:0] w_pend;
    logic            w_any_busy;

    // Load writeback (port B) takes priority over ALU writeback on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (!(ZERO_R0 != 0 && i == 0)) begin
                    if (wb_en && wb_addr == AW'(i)) begin
                        r_mem[i] <= wb_data;
                    end else if (wa_en && wa_addr == AW'(i)) begin
                        r_mem[i] <= wa_data;
                    end
                end
            end
        end
    end

    zmips_sb_vec #(
        .NREG    (NREG),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_sb_vec (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_addr (sb_addr),
        .clr_en   (wb_en & wb_clr),
        .clr_addr (wb_addr),
        .pend     (w_pend),
        .any_busy (w_any_busy)
    );

    assign any_busy = w_any_busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        logic          w_busy;

        assign w_addr = rd_addr[k*AW +: AW];

        // Outputs are forced to zero while in reset so bypass data cannot leak through.
        always_comb begin
            w_data = r_mem[w_addr];
            w_busy = w_pend[w_addr];
            if (BYPASS != 0) begin
                if (wb_en && wb_addr == w_addr) begin
                    w_data = wb_data;
                    if (wb_clr) begin
                        w_busy = 1'b0;
                    end
                end else if (wa_en && wa_addr == w_addr) begin
                    w_data = wa_data;
                end
            end
            if (rst || (ZERO_R0 != 0 && w_addr == W_ZERO_ADDR)) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data[k*DW +: DW] = w_data;
        assign rd_busy[k]          = w_busy;
    end

endmodule
